// File: rtl/cm0_core_smul_seq.sv
// MSB-first shift-and-add sequencer for the small-multiplier core configuration.
// Walks the 32:1 multiplicand mux over 32 cycles and strobes done with the low product word.
module cm0_core_smul_seq #(
    parameter int unsigned SMUL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_start_i,
    input  logic        mul_kill_i,
    input  logic [31:0] gpr_rb_data_lo_i,
    input  logic        mul_sel_i,
    output logic [4:0]  smul_imm_o,
    output logic        mul_busy_o,
    output logic        mul_done_o,
    output logic [31:0] mul_res_o
);

    localparam logic Active = (SMUL != 0);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [31:0] opb_q;
    logic [31:0] acc_q;
    logic [5:0]  cnt_q;
    logic [4:0]  imm_q;
    logic [31:0] acc_step;

    // Horner step: the selected multiplier bit arrives MSB-first, carry-out is dropped.
    assign acc_step = {acc_q[30:0], 1'b0} + (mul_sel_i ? opb_q : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            imm_q   <= '0;
        end else if (!Active) begin
            state_q <= StIdle;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            imm_q   <= '0;
        end else if (mul_kill_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            imm_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (mul_start_i) begin
                        state_q <= StRun;
                        opb_q   <= gpr_rb_data_lo_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        imm_q   <= 5'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    imm_q <= imm_q + 5'd1;
                    cnt_q <= cnt_q + 6'd1;
                    // imm wraps to 0 on the last step, which selects opa[0].
                    if (imm_q == 5'd0) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        smul_imm_o = (state_q == StRun) ? imm_q : 5'd0;
        mul_busy_o = (state_q == StRun);
        mul_done_o = (state_q == StDone);
        mul_res_o  = Active ? acc_q : 32'd0;
    end

endmodule

// File: tb/tb_cm0_core_smul_seq.sv
// Bench for cm0_core_smul_seq: timeline model of the multiply compared every cycle,
// directed scenarios pinned with literal products, then randomized operands/kills.
module tb_cm0_core_smul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        sel;
    logic [31:0] rb = '0;
    logic [31:0] opa = '0;

    logic [4:0]  imm, z_imm;
    logic        busy, done, z_busy, z_done;
    logic [31:0] res, z_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cm0_core_smul_seq #(.SMUL(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mul_start_i      (start),
        .mul_kill_i       (kill),
        .gpr_rb_data_lo_i (rb),
        .mul_sel_i        (sel),
        .smul_imm_o       (imm),
        .mul_busy_o       (busy),
        .mul_done_o       (done),
        .mul_res_o        (res)
    );

    cm0_core_smul_seq #(.SMUL(0)) dut_off (
        .clk              (clk),
        .rst_n            (rst_n),
        .mul_start_i      (start),
        .mul_kill_i       (kill),
        .gpr_rb_data_lo_i (rb),
        .mul_sel_i        (sel),
        .smul_imm_o       (z_imm),
        .mul_busy_o       (z_busy),
        .mul_done_o       (z_done),
        .mul_res_o        (z_res)
    );

    // Core mux: imm 1..31 -> opa[31..1], imm 0 -> opa[0].
    function automatic int mux_idx(input logic [4:0] s);
        return (s == 5'd0) ? 0 : 32 - int'(s);
    endfunction
    assign sel = opa[mux_idx(imm)];

    // Model: m_t = cycle number since accepted start (0 = idle, 1..32 run, 33 done).
    int          m_t = 0;
    logic [31:0] m_opa = '0;
    logic [31:0] m_opb = '0;
    logic [31:0] m_res = '0;

    // Accumulator after k steps = (top k bits of opa) * opb, low 32 bits.
    function automatic logic [31:0] partial(input int k);
        logic [63:0] a;
        logic [63:0] p;
        a = {32'd0, m_opa} >> (32 - k);
        p = a * {32'd0, m_opb};
        return p[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            m_res <= '0;
        end else if (kill) begin
            m_t   <= 0;
            m_res <= '0;
        end else if ((m_t == 0 || m_t == 33) && start) begin
            m_t   <= 1;
            m_opa <= opa;
            m_opb <= rb;
            m_res <= '0;
        end else if (m_t >= 1 && m_t <= 32) begin
            m_t <= m_t + 1;
        end else if (m_t == 33) begin
            m_t   <= 0;
            m_res <= partial(32);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h want 0x%08h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        e_busy;
        logic        e_done;
        logic [4:0]  e_imm;
        logic [31:0] e_res;
        e_busy = (m_t >= 1 && m_t <= 32);
        e_done = (m_t == 33);
        e_imm  = e_busy ? 5'(m_t % 32) : 5'd0;
        e_res  = e_busy ? partial(m_t - 1) : (e_done ? partial(32) : m_res);
        chk("imm", 32'(imm), 32'(e_imm));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("res", res, e_res);
        chk("off_out", {z_res[31:5], z_res[4:0] | z_imm, z_busy, z_done}, '0);
    end

    // Called just after the start edge; n0 = negedges of this run already consumed.
    task automatic wait_done(input logic [31:0] lit, input string nm, input int n0,
                             input bit walk);
        int n;
        bit got;
        n = n0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (walk && n <= 32) chk({nm, "_walk"}, 32'(imm), 32'(n % 32));
            if (done) got = 1'b1;
        end
        chk({nm, "_lat"}, 32'(n), 32'd33);
        chk({nm, "_res"}, res, lit);
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        opa   = a;
        rb    = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_res", res, '0);
        chk("rst_ctl", {27'd0, imm} | {31'd0, busy} | {31'd0, done}, '0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Small product with an explicit walk of the bit-select.
        pulse_start(32'h0000_0003, 32'h0000_0005);
        wait_done(32'h0000_000F, "s1", 0, 1'b1);
        @(posedge clk);
        #1;

        // Wraparound and truncation.
        pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'h0000_0001, "s2a", 0, 1'b0);
        pulse_start(32'h8000_0000, 32'h0000_0002);
        wait_done(32'h0000_0000, "s2b", 0, 1'b0);
        @(negedge clk);
        chk("s2_hold", res, 32'h0000_0000);

        // Start during RUN is ignored.
        pulse_start(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        rb    = 32'hDEAD_BEEF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(32'h242D_2080, "s3", 9, 1'b0);
        repeat (2) @(negedge clk);
        chk("s3_hold", res, 32'h242D_2080);

        // Kill mid-run, then a clean restart.
        pulse_start(32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_imm", 32'(imm), 32'd0);
        chk("s4_res", res, 32'd0);
        repeat (30) @(negedge clk);
        chk("s4_nodone", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        pulse_start(32'h0000_0009, 32'h0000_000B);
        wait_done(32'h0000_0063, "s4b", 0, 1'b0);

        // Back-to-back start in the DONE cycle.
        @(posedge clk);
        #1;
        pulse_start(32'h0001_0000, 32'h0000_0003);
        wait_done(32'h0003_0000, "s5a", 0, 1'b0);
        opa   = 32'd7;
        rb    = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(32'h0000_002A, "s5b", 0, 1'b0);

        // Kill during DONE: strobe already visible, result cleared next cycle.
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kd_res", res, 32'd0);
        chk("kd_done", 32'(done), 32'd0);

        // Asynchronous reset mid-run.
        pulse_start(32'hFFFF_0000, 32'h0000_FFFF);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_res", res, 32'd0);
        chk("s6_ctl", {27'd0, imm} | {31'd0, busy} | {31'd0, done}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized operands with occasional kills and ignored starts.
        for (int it = 0; it < 25; it++) begin
            int mode;
            int kc;
            int sc;
            mode = int'($urandom_range(0, 3));
            kc   = (mode == 0) ? int'($urandom_range(1, 33)) : 0;
            sc   = (mode == 1) ? int'($urandom_range(2, 30)) : 0;
            pulse_start($urandom, $urandom);
            for (int c = 1; c <= 33; c++) begin
                @(negedge clk);
                if (c == kc) kill = 1'b1;
                if (c == sc) begin
                    start = 1'b1;
                    rb    = $urandom;
                end
                @(posedge clk);
                #1;
                kill  = 1'b0;
                start = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        @(negedge clk);
        chk("off_final", z_res, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
